// File: rtl/frame_config_loader_if.sv
// Word-stream input and frame-latch output bundle for frame_config_loader.
// The upstream word source uses master, the loader uses slave.
interface frame_config_loader_if #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20
);
  logic [31:0]                WordData;
  logic                       WordValid;
  logic                       WordReady;
  logic [FrameBitsPerRow-1:0] FrameData;
  logic [MaxFramesPerCol-1:0] FrameStrobe;
  logic [7:0]                 ColumnSelect;
  logic                       Busy;
  logic                       ConfigDone;
  logic                       ConfigErr;

  modport master (
    output WordData, WordValid,
    input  WordReady, FrameData, FrameStrobe, ColumnSelect, Busy, ConfigDone, ConfigErr
  );

  modport slave (
    input  WordData, WordValid,
    output WordReady, FrameData, FrameStrobe, ColumnSelect, Busy, ConfigDone, ConfigErr
  );
endinterface

// File: rtl/frame_config_loader.sv
// Parses a sync/header/data word stream and drives frame latches with a
// SETUP -> STROBE -> HOLD sequence per frame so data is stable around each strobe.
module frame_config_loader #(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          NumColumns      = 16,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
  input logic                  CLK,
  input logic                  RESET,
  frame_config_loader_if.slave bus
);

  localparam int             IdxW        = 5;
  localparam logic [7:0]     NumColumnsW = 8'(NumColumns);
  localparam logic [16:0]    MaxFramesW  = 17'(MaxFramesPerCol);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_e;

  state_e                     state_q, state_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic [7:0]                 col_q, col_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [15:0]                rem_q, rem_d;
  logic                       err_q, err_d;
  logic                       done_q, done_d;

  logic        word_ready;
  logic        accept;
  logic [7:0]  hdr_col;
  logic [7:0]  hdr_start;
  logic [15:0] hdr_count;
  logic [16:0] hdr_end;

  assign word_ready = (state_q == S_IDLE) || (state_q == S_HEADER) || (state_q == S_DATA);
  assign accept     = word_ready && bus.WordValid;

  assign hdr_col   = bus.WordData[31:24];
  assign hdr_start = bus.WordData[23:16];
  assign hdr_count = bus.WordData[15:0];
  // Widened sum so a huge count cannot wrap back into the legal range.
  assign hdr_end   = {9'b0, hdr_start} + {1'b0, hdr_count};

  // NOTE: every variable gets its hold value before the case so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    col_d    = col_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    err_d    = err_q;
    done_d   = 1'b0;
    strobe_d = '0;

    case (state_q)
      S_IDLE: begin
        if (accept && bus.WordData == SyncWord) begin
          err_d   = 1'b0;
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        if (accept) begin
          if (hdr_count == 16'd0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (hdr_col >= NumColumnsW || hdr_end > MaxFramesW) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            col_d   = hdr_col;
            idx_d   = hdr_start[IdxW-1:0];
            rem_d   = hdr_count;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          data_d  = bus.WordData;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        // Strobe is registered so the latch enable is glitch-free.
        strobe_d[idx_q] = 1'b1;
        state_d         = S_STROBE;
      end
      S_STROBE: state_d = S_HOLD;
      S_HOLD: begin
        idx_d   = idx_q + 5'd1;
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q == 16'd1) ? S_HEADER : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      strobe_q <= '0;
      col_q    <= '0;
      idx_q    <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      col_q    <= col_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign bus.WordReady    = word_ready;
  assign bus.FrameData    = data_q;
  assign bus.FrameStrobe  = strobe_q;
  assign bus.ColumnSelect = col_q;
  assign bus.Busy         = (state_q != S_IDLE);
  assign bus.ConfigDone   = done_q;
  assign bus.ConfigErr    = err_q;

endmodule

// File: tb/tb_frame_config_loader.sv
// Self-checking bench for frame_config_loader: header decode table, hand-written
// timing/reset sequences and random streams against a word-level reference model.
module tb_frame_config_loader;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  typedef struct packed {
    logic [7:0]  col;
    logic [4:0]  idx;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    string       name;
    logic [31:0] hdr;
    logic        exp_done;
    logic        exp_err;
    logic        exp_busy;
    logic [7:0]  exp_col;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  frame_config_loader_if #(.FrameBitsPerRow(32), .MaxFramesPerCol(20)) bus ();

  frame_config_loader dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Passive monitor: records every strobe and counts latch-timing violations.
  ev_t         events [4096];
  int          ev_wr     = 0;
  int          done_seen = 0;
  int          viol      = 0;
  logic        prev_strobe = 1'b0;
  logic [31:0] prev_data   = '0;

  always @(negedge CLK) begin
    if (RESET) begin
      prev_strobe = 1'b0;
      prev_data   = bus.FrameData;
    end else begin
      if (bus.ConfigDone) done_seen++;
      if (bus.ConfigDone && bus.ConfigErr) viol++;
      if (prev_strobe && (bus.FrameStrobe != '0 || bus.FrameData != prev_data)) viol++;
      if (bus.FrameStrobe != '0) begin
        if (!$onehot(bus.FrameStrobe) || bus.FrameData != prev_data) viol++;
        if (ev_wr < 4096) begin
          for (int k = 0; k < 20; k++)
            if (bus.FrameStrobe[k]) events[ev_wr].idx = 5'(k);
          events[ev_wr].col  = bus.ColumnSelect;
          events[ev_wr].data = bus.FrameData;
          ev_wr++;
        end
      end
      prev_strobe = |bus.FrameStrobe;
      prev_data   = bus.FrameData;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    #1 RESET = 1'b1;
    bus.WordValid = 1'b0;
    bus.WordData  = '0;
    @(negedge CLK);
    @(negedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
  endtask

  // Presents a word, waits (bounded) for ready, completes the transfer and
  // returns at the falling edge after the accepting edge with WordValid low.
  task automatic send_word(input logic [31:0] w, input int gap);
    int waited;
    repeat (gap) @(negedge CLK);
    bus.WordData  = w;
    bus.WordValid = 1'b1;
    waited = 0;
    while (!bus.WordReady && waited < 64) begin
      @(negedge CLK);
      waited++;
    end
    if (!bus.WordReady) begin
      check("send_ready_timeout", {63'd0, bus.WordReady}, 64'd1);
      bus.WordValid = 1'b0;
      return;
    end
    @(posedge CLK);
    @(negedge CLK);
    bus.WordValid = 1'b0;
  endtask

  // One frame from a DATA-state acceptance: SETUP, STROBE, HOLD, then ready again.
  task automatic frame_timing(input logic [31:0] d, input logic [19:0] strobe);
    send_word(d, 0);
    check("setup_strobe", bus.FrameStrobe, 0);
    check("setup_data", bus.FrameData, d);
    check("setup_ready", bus.WordReady, 0);
    @(negedge CLK);
    check("strobe_value", bus.FrameStrobe, strobe);
    check("strobe_data", bus.FrameData, d);
    @(negedge CLK);
    check("hold_strobe", bus.FrameStrobe, 0);
    check("hold_ready", bus.WordReady, 0);
    check("hold_data", bus.FrameData, d);
    @(negedge CLK);
    check("ready_after_frame", bus.WordReady, 1);
  endtask

  // Word-level reference: walks the stream as sync / header / data records.
  logic [31:0] stim_q[$];
  ev_t         exp_q[$];
  int          exp_done;
  logic        exp_err;

  task automatic run_model();
    int          i;
    logic        armed;
    logic [31:0] w;
    int          col, start, cnt;
    i        = 0;
    armed    = 1'b0;
    exp_done = 0;
    exp_err  = 1'b0;
    exp_q.delete();
    while (i < stim_q.size()) begin
      w = stim_q[i];
      i++;
      if (!armed) begin
        if (w == SYNC) begin
          armed   = 1'b1;
          exp_err = 1'b0;
        end
      end else begin
        col   = int'(w[31:24]);
        start = int'(w[23:16]);
        cnt   = int'(w[15:0]);
        if (cnt == 0) begin
          exp_done++;
          armed = 1'b0;
        end else if (col >= 16 || start + cnt > 20) begin
          exp_err = 1'b1;
          armed   = 1'b0;
        end else begin
          for (int k = 0; k < cnt && i < stim_q.size(); k++) begin
            exp_q.push_back('{col: 8'(col), idx: 5'(start + k), data: stim_q[i]});
            i++;
          end
        end
      end
    end
  endtask

  vec_t vecs [12];

  initial begin
    logic [31:0] fd;
    int          bad;
    int          ev_base, done_base;
    logic [7:0]  r_col, r_start;
    logic [15:0] r_cnt;

    vecs[0]  = '{"col15_ok",          32'h0F00_0001, 1'b0, 1'b0, 1'b1, 8'h0F};
    vecs[1]  = '{"col16_err",         32'h1000_0001, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{"start18_cnt2_ok",   32'h0712_0002, 1'b0, 1'b0, 1'b1, 8'h07};
    vecs[3]  = '{"start18_cnt3_err",  32'h0712_0003, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{"start19_cnt1_ok",   32'h0913_0001, 1'b0, 1'b0, 1'b1, 8'h09};
    vecs[5]  = '{"start20_cnt1_err",  32'h0914_0001, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[6]  = '{"start0_cnt20_ok",   32'h0A00_0014, 1'b0, 1'b0, 1'b1, 8'h0A};
    vecs[7]  = '{"start1_cnt20_err",  32'h0A01_0014, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{"no_wrap_err",       32'h0A01_FFFF, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[9]  = '{"max_fields_err",    32'h0AFF_FFFF, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[10] = '{"count0_done",       32'hFF00_0000, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{"count0_bigstart",   32'h01FF_0000, 1'b1, 1'b0, 1'b0, 8'h00};

    bus.WordData  = '0;
    bus.WordValid = 1'b0;

    // Reset values and the basic two-frame write.
    do_reset();
    check("rst_ready", bus.WordReady, 1);
    check("rst_data", bus.FrameData, 0);
    check("rst_strobe", bus.FrameStrobe, 0);
    check("rst_col", bus.ColumnSelect, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.ConfigDone, 0);
    check("rst_err", bus.ConfigErr, 0);
    send_word(32'h1234_5678, 0);
    check("garbage_stays_idle", bus.Busy, 0);
    send_word(SYNC, 0);
    check("sync_busy", bus.Busy, 1);
    send_word(32'h0300_0002, 0);
    check("hdr_col3", bus.ColumnSelect, 3);
    frame_timing(32'hAAAA_5555, 20'h00001);
    frame_timing(32'h0F0F_F0F0, 20'h00002);
    check("back_in_header", bus.Busy, 1);
    send_word(32'h0000_0000, 0);
    check("desync_done", bus.ConfigDone, 1);
    check("desync_busy", bus.Busy, 0);
    check("desync_no_err", bus.ConfigErr, 0);
    @(negedge CLK);
    check("done_one_cycle", bus.ConfigDone, 0);

    // Error set by bad column, cleared by the next sync.
    send_word(SYNC, 0);
    send_word(32'h1000_0001, 0);
    check("col16_err", bus.ConfigErr, 1);
    check("col16_idle", bus.Busy, 0);
    send_word(SYNC, 0);
    check("sync_clears_err", bus.ConfigErr, 0);
    send_word(32'h0000_0000, 0);

    // Last frames of a column.
    send_word(SYNC, 0);
    send_word(32'h0012_0003, 0);
    check("s18c3_err", bus.ConfigErr, 1);
    send_word(SYNC, 0);
    send_word(32'h0012_0002, 0);
    check("s18c2_accepted", bus.Busy, 1);
    frame_timing(32'h1111_2222, 20'h40000);
    frame_timing(32'h3333_4444, 20'h80000);
    check("s18c2_header", bus.Busy, 1);
    send_word(32'h0000_0000, 0);

    // Stall in DATA, then a word held valid through SETUP/STROBE/HOLD.
    send_word(SYNC, 0);
    send_word(32'h0500_0001, 0);
    fd  = bus.FrameData;
    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (bus.FrameStrobe != '0 || bus.FrameData != fd || !bus.WordReady || !bus.Busy) bad++;
    end
    check("stall_stable_cycles", bad, 0);
    send_word(32'h5A5A_A5A5, 0);
    bus.WordData  = 32'h0000_0000;
    bus.WordValid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("busy_not_ready_c%0d", k), bus.WordReady, 0);
      check($sformatf("busy_data_held_c%0d", k), bus.FrameData, 32'h5A5A_A5A5);
      @(negedge CLK);
    end
    check("ready_in_header", bus.WordReady, 1);
    @(posedge CLK);
    @(negedge CLK);
    bus.WordValid = 1'b0;
    check("held_word_as_header_done", bus.ConfigDone, 1);
    check("held_word_idle", bus.Busy, 0);

    // Header decode table.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      send_word(SYNC, 0);
      send_word(vecs[i].hdr, 0);
      check({vecs[i].name, "_done"}, bus.ConfigDone, vecs[i].exp_done);
      check({vecs[i].name, "_err"}, bus.ConfigErr, vecs[i].exp_err);
      check({vecs[i].name, "_busy"}, bus.Busy, vecs[i].exp_busy);
      check({vecs[i].name, "_col"}, bus.ColumnSelect, vecs[i].exp_col);
    end

    // Random streams against the reference model.
    for (int run = 0; run < 20; run++) begin
      stim_q.delete();
      repeat (6) begin
        if ($urandom_range(0, 7) == 0) stim_q.push_back($urandom);
        if ($urandom_range(0, 9) != 0) stim_q.push_back(SYNC);
        repeat ($urandom_range(1, 3)) begin
          r_col   = 8'($urandom_range(0, 17));
          r_start = 8'($urandom_range(0, 21));
          r_cnt   = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
          stim_q.push_back({r_col, r_start, r_cnt});
          for (int k = 0; k < int'(r_cnt) && k < 3; k++)
            stim_q.push_back(($urandom_range(0, 7) == 0) ? SYNC : 32'($urandom));
        end
      end
      run_model();
      do_reset();
      ev_base   = ev_wr;
      done_base = done_seen;
      foreach (stim_q[i])
        send_word(stim_q[i], ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
      repeat (6) @(negedge CLK);
      check($sformatf("rand%0d_frames", run), ev_wr - ev_base, exp_q.size());
      foreach (exp_q[k])
        if (ev_base + k < ev_wr)
          check($sformatf("rand%0d_frame%0d", run, k), events[ev_base + k], exp_q[k]);
      check($sformatf("rand%0d_done_pulses", run), done_seen - done_base, exp_done);
      check($sformatf("rand%0d_err", run), bus.ConfigErr, exp_err);
    end

    // Asynchronous reset in the middle of a strobe.
    do_reset();
    send_word(SYNC, 0);
    send_word(32'h0200_0001, 0);
    send_word(32'hC3C3_3C3C, 0);
    @(negedge CLK);
    check("pre_reset_strobe", bus.FrameStrobe, 20'h00001);
    #1 RESET = 1'b1;
    #1;
    check("async_rst_strobe", bus.FrameStrobe, 0);
    check("async_rst_ready", bus.WordReady, 1);
    check("async_rst_busy", bus.Busy, 0);
    check("async_rst_data", bus.FrameData, 0);
    @(negedge CLK);
    #1 RESET = 1'b0;
    ev_base = ev_wr;
    send_word(32'h0200_0001, 0);
    send_word(32'hDEAD_BEEF, 0);
    repeat (4) @(negedge CLK);
    check("post_rst_ignored_busy", bus.Busy, 0);
    check("post_rst_no_strobe", ev_wr - ev_base, 0);
    check("post_rst_col", bus.ColumnSelect, 0);

    check("latch_timing_violations", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
